// File: rtl/bus_fifo_port.sv
// bus_fifo_port: memory-mapped TX/RX FIFO peripheral on the CPU data bus.
// CPU stores to DATA push the TX FIFO, which an external sink drains.
// CPU loads from DATA pop the RX FIFO, which an external source fills.
// Load data is registered so it lands in the CPU write-back stage.

// Circular-buffer FIFO shared by the TX and RX paths.
module bus_fifo_core #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 32,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] head,
    output logic [CW-1:0]    count,
    output logic             empty,
    output logic             full
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));

    // A pop in the same cycle frees a slot, so a push into a full FIFO is
    // still taken. Clear overrides any traffic on the same edge.
    assign do_pop  = !clr && pop && !empty;
    assign do_push = !clr && push && (!full || do_pop);

    // Head word straight from storage; forced to 0 while empty.
    assign head = empty ? '0 : mem[rd_ptr];

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: contents are only visible while count != 0.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end
endmodule

// Register map and bus glue around the two FIFOs.
module bus_fifo_port #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 32,
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic             CLK,
    input  logic             Rst,
    input  logic             CS,
    input  logic             WR_RD,
    input  logic [31:0]      ADDR,
    input  logic [WIDTH-1:0] Data_BUS_WRITE,
    output logic [WIDTH-1:0] Data_BUS_READ,
    output logic [WIDTH-1:0] tx_data,
    output logic             tx_valid,
    input  logic             tx_ready,
    input  logic [WIDTH-1:0] rx_data,
    input  logic             rx_valid,
    output logic             rx_ready,
    output logic             irq
);
    localparam logic [1:0] SEL_DATA = 2'd0;
    localparam logic [1:0] SEL_STAT = 2'd1;
    localparam logic [1:0] SEL_CTRL = 2'd2;

    typedef struct packed {
        logic       wr;
        logic       rd;
        logic [1:0] sel;
    } bus_req_t;

    bus_req_t         req;
    logic             en, ie_rx, ie_tx, ovf, unf;
    logic             ctrl_wr, clr, flagclr;
    logic             tx_cpu_push, tx_pop, rx_push, rx_cpu_pop;
    logic             ovf_evt, unf_evt;
    logic [WIDTH-1:0] rx_head;
    logic [CW-1:0]    tx_cnt, rx_cnt;
    logic             tx_empty, tx_full, rx_empty, rx_full;
    logic [31:0]      tx_cnt32, rx_cnt32, status;
    logic             unused_bits;

    // Decode the bus access for this cycle.
    always_comb begin
        req     = '0;
        req.wr  = CS && WR_RD;
        req.rd  = CS && !WR_RD;
        req.sel = ADDR[1:0];
    end

    assign ctrl_wr = req.wr && (req.sel == SEL_CTRL);
    assign clr     = ctrl_wr && Data_BUS_WRITE[3];
    assign flagclr = ctrl_wr && Data_BUS_WRITE[4];

    assign tx_cpu_push = req.wr && (req.sel == SEL_DATA);
    assign rx_cpu_pop  = req.rd && (req.sel == SEL_DATA);

    // External handshakes are frozen while disabled.
    assign tx_valid = en && !tx_empty;
    assign rx_ready = en && !rx_full;
    assign tx_pop   = tx_valid && tx_ready;
    assign rx_push  = rx_valid && rx_ready;

    assign ovf_evt = tx_cpu_push && tx_full && !tx_pop;
    assign unf_evt = rx_cpu_pop && rx_empty;

    assign irq = (!rx_empty && ie_rx) || (tx_empty && ie_tx);

    bus_fifo_core #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_tx (
        .clk   (CLK),
        .rst_n (Rst),
        .clr   (clr),
        .push  (tx_cpu_push),
        .pop   (tx_pop),
        .wdata (Data_BUS_WRITE),
        .head  (tx_data),
        .count (tx_cnt),
        .empty (tx_empty),
        .full  (tx_full)
    );

    bus_fifo_core #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_rx (
        .clk   (CLK),
        .rst_n (Rst),
        .clr   (clr),
        .push  (rx_push),
        .pop   (rx_cpu_pop),
        .wdata (rx_data),
        .head  (rx_head),
        .count (rx_cnt),
        .empty (rx_empty),
        .full  (rx_full)
    );

    // STATUS word; counts zero-extended then cut to 8 bits.
    always_comb begin
        tx_cnt32 = 32'(tx_cnt);
        rx_cnt32 = 32'(rx_cnt);
        status   = '0;
        status[23:16] = rx_cnt32[7:0];
        status[15:8]  = tx_cnt32[7:0];
        status[5]     = ovf;
        status[4]     = unf;
        status[3]     = rx_full;
        status[2]     = rx_empty;
        status[1]     = tx_full;
        status[0]     = tx_empty;
    end

    // Control bits and sticky error flags; a fresh event beats FLAGCLR.
    always_ff @(posedge CLK or negedge Rst) begin
        if (!Rst) begin
            en    <= 1'b0;
            ie_rx <= 1'b0;
            ie_tx <= 1'b0;
            ovf   <= 1'b0;
            unf   <= 1'b0;
        end else begin
            if (ctrl_wr) begin
                en    <= Data_BUS_WRITE[0];
                ie_rx <= Data_BUS_WRITE[1];
                ie_tx <= Data_BUS_WRITE[2];
            end
            ovf <= (ovf && !flagclr) || ovf_evt;
            unf <= (unf && !flagclr) || unf_evt;
        end
    end

    // Load data register: captured at the access edge, held until next load.
    // An empty-RX pop returns 0 because the FIFO head reads 0 when empty.
    always_ff @(posedge CLK or negedge Rst) begin
        if (!Rst) begin
            Data_BUS_READ <= '0;
        end else if (req.rd) begin
            case (req.sel)
                SEL_DATA: Data_BUS_READ <= rx_head;
                SEL_STAT: Data_BUS_READ <= WIDTH'(status);
                SEL_CTRL: Data_BUS_READ <= WIDTH'({ie_tx, ie_rx, en});
                default:  Data_BUS_READ <= '0;
            endcase
        end
    end

    assign unused_bits = ^{ADDR[31:2], Data_BUS_WRITE[WIDTH-1:5]};
endmodule

// File: tb/tb_bus_fifo_port.sv
// Directed bench for bus_fifo_port: register map, FIFO flow, flags, irq, reset.
module tb_bus_fifo_port;
    logic        CLK = 1'b0;
    logic        Rst = 1'b0;
    logic        CS = 1'b0;
    logic        WR_RD = 1'b0;
    logic [31:0] ADDR = '0;
    logic [31:0] Data_BUS_WRITE = '0;
    logic [31:0] Data_BUS_READ;
    logic [31:0] tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic [31:0] rx_data = '0;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic        irq;

    int total = 0;
    int bad = 0;

    bus_fifo_port #(.DEPTH(8), .WIDTH(32)) dut (
        .CLK            (CLK),
        .Rst            (Rst),
        .CS             (CS),
        .WR_RD          (WR_RD),
        .ADDR           (ADDR),
        .Data_BUS_WRITE (Data_BUS_WRITE),
        .Data_BUS_READ  (Data_BUS_READ),
        .tx_data        (tx_data),
        .tx_valid       (tx_valid),
        .tx_ready       (tx_ready),
        .rx_data        (rx_data),
        .rx_valid       (rx_valid),
        .rx_ready       (rx_ready),
        .irq            (irq)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        CS = 1'b1; WR_RD = 1'b1; ADDR = {30'd0, a}; Data_BUS_WRITE = d;
        cyc();
        CS = 1'b0; WR_RD = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string tag);
        CS = 1'b1; WR_RD = 1'b0; ADDR = {30'd0, a};
        cyc();
        CS = 1'b0;
        check(tag, Data_BUS_READ, exp);
    endtask

    initial begin
        // 1: reset with partially filled FIFOs
        cyc(); cyc();
        Rst = 1'b1;
        cyc();
        wr(2, 32'h1);
        wr(0, 32'h1);
        wr(0, 32'h2);
        check("t1_txv", {31'd0, tx_valid}, 32'd1);
        check("t1_txd", tx_data, 32'h1);
        rx_valid = 1'b1; rx_data = 32'h77;
        cyc();
        rx_valid = 1'b0;
        rd(1, 32'h0001_0200, "t1_stat_pre");
        #2 Rst = 1'b0;
        #1;
        check("t1_rst_out", {Data_BUS_READ[0], tx_valid, rx_ready, irq}, 32'd0);
        check("t1_rst_txd", tx_data, 32'h0);
        check("t1_rst_rd", Data_BUS_READ, 32'h0);
        cyc();
        Rst = 1'b1;
        cyc();
        rd(1, 32'h0000_0005, "t1_stat_post");

        // 2: fill TX, overflow, drain in order
        wr(2, 32'h1);
        for (int i = 0; i < 8; i++) wr(0, 32'hA0 + i);
        rd(1, 32'h0000_0806, "t2_full");
        wr(0, 32'hA8);
        rd(1, 32'h0000_0826, "t2_ovf");
        tx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("t2_drain_v%0d", i), {31'd0, tx_valid}, 32'd1);
            check($sformatf("t2_drain_d%0d", i), tx_data, 32'hA0 + i);
            cyc();
        end
        check("t2_empty_v", {31'd0, tx_valid}, 32'd0);
        check("t2_empty_d", tx_data, 32'h0);
        tx_ready = 1'b0;
        wr(2, 32'h11);
        rd(1, 32'h0000_0005, "t2_flagclr");

        // 3: RX path and underflow
        rx_valid = 1'b1; rx_data = 32'h11;
        check("t3_rxr", {31'd0, rx_ready}, 32'd1);
        cyc();
        rx_data = 32'h22;
        cyc();
        rx_data = 32'h33;
        cyc();
        rx_valid = 1'b0;
        rd(1, 32'h0003_0001, "t3_stat");
        rd(0, 32'h11, "t3_rd0");
        rd(0, 32'h22, "t3_rd1");
        rd(0, 32'h33, "t3_rd2");
        cyc();
        check("t3_hold", Data_BUS_READ, 32'h33);
        rd(0, 32'h0, "t3_rd_unf");
        rd(1, 32'h0000_0015, "t3_unf");
        wr(2, 32'h11);

        // 4: push+pop while full, then pointer wrap
        for (int i = 0; i < 8; i++) wr(0, 32'hC0 + i);
        CS = 1'b1; WR_RD = 1'b1; ADDR = 32'd0; Data_BUS_WRITE = 32'hBB; tx_ready = 1'b1;
        cyc();
        CS = 1'b0; WR_RD = 1'b0; tx_ready = 1'b0;
        rd(1, 32'h0000_0806, "t4_still_full");
        tx_ready = 1'b1;
        for (int i = 1; i < 8; i++) begin
            check($sformatf("t4_d%0d", i), tx_data, 32'hC0 + i);
            cyc();
        end
        check("t4_bb", tx_data, 32'hBB);
        cyc();
        tx_ready = 1'b0;
        check("t4_empty", {31'd0, tx_valid}, 32'd0);
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 8; i++) wr(0, 32'h100 * (r + 1) + i);
            tx_ready = 1'b1;
            for (int i = 0; i < 8; i++) begin
                check($sformatf("t4_wrap_r%0d_%0d", r, i), tx_data, 32'h100 * (r + 1) + i);
                cyc();
            end
            tx_ready = 1'b0;
        end
        rd(1, 32'h0000_0005, "t4_wrap_end");

        // 5: interrupts and CLR
        wr(2, 32'h3);
        check("t5_irq0", {31'd0, irq}, 32'd0);
        rx_valid = 1'b1; rx_data = 32'h55;
        cyc();
        rx_valid = 1'b0;
        check("t5_irq_rx", {31'd0, irq}, 32'd1);
        rd(0, 32'h55, "t5_pop");
        check("t5_irq_pop", {31'd0, irq}, 32'd0);
        wr(0, 32'h66);
        rx_valid = 1'b1; rx_data = 32'h77;
        cyc();
        rx_valid = 1'b0;
        rd(1, 32'h0001_0100, "t5_pre_clr");
        CS = 1'b1; WR_RD = 1'b1; ADDR = 32'd2; Data_BUS_WRITE = 32'h0B;
        tx_ready = 1'b1; rx_valid = 1'b1; rx_data = 32'h88;
        cyc();
        CS = 1'b0; WR_RD = 1'b0; tx_ready = 1'b0; rx_valid = 1'b0;
        check("t5_clr_irq", {31'd0, irq}, 32'd0);
        rd(1, 32'h0000_0005, "t5_clr_stat");
        rd(2, 32'h3, "t5_ctrl");
        wr(2, 32'h5);
        check("t5_irq_tx", {31'd0, irq}, 32'd1);
        wr(2, 32'h1);
        check("t5_irq_off", {31'd0, irq}, 32'd0);

        // 6: async reset mid-stream, then disabled external side
        wr(0, 32'h99);
        rd(2, 32'h1, "t6_ctrl");
        rx_valid = 1'b1; rx_data = 32'hAB; tx_ready = 1'b1;
        #2 Rst = 1'b0;
        #1;
        check("t6_rst_txv", {31'd0, tx_valid}, 32'd0);
        check("t6_rst_rxr", {31'd0, rx_ready}, 32'd0);
        check("t6_rst_txd", tx_data, 32'h0);
        check("t6_rst_rd", Data_BUS_READ, 32'h0);
        #3 Rst = 1'b1;
        cyc(); cyc(); cyc();
        check("t6_frozen", {30'd0, tx_valid, rx_ready}, 32'd0);
        rx_valid = 1'b0; tx_ready = 1'b0;
        rd(1, 32'h0000_0005, "t6_stat");
        wr(0, 32'h42);
        check("t6_en0_txv", {31'd0, tx_valid}, 32'd0);
        check("t6_en0_txd", tx_data, 32'h42);
        rd(1, 32'h0000_0104, "t6_stat2");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
